// File: rtl/id_ex_stage.sv
// Decode/issue stage feeding the ALU: decodes RV32I, forwards operands from
// EX/MEM and MEM/WB, inserts a bubble on load-use, and registers ALU inputs.
module id_ex_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  input  logic [XLEN-1:0]   pc,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [XLEN-1:0]   rs2_data,
  input  logic              stall,
  input  logic              flush,
  input  logic              fwd1_valid,
  input  logic [REG_AW-1:0] fwd1_rd,
  input  logic [XLEN-1:0]   fwd1_data,
  input  logic              fwd2_valid,
  input  logic [REG_AW-1:0] fwd2_rd,
  input  logic [XLEN-1:0]   fwd2_data,
  output logic              out_valid,
  output logic [1:0]        aluop,
  output logic [9:0]        funccode,
  output logic [XLEN-1:0]   alu_a,
  output logic [XLEN-1:0]   alu_b,
  output logic [XLEN-1:0]   store_data,
  output logic [REG_AW-1:0] out_rd,
  output logic [XLEN-1:0]   out_pc,
  output logic              mem_read,
  output logic              mem_write,
  output logic              branch,
  output logic              reg_write,
  output logic              illegal
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [REG_AW-1:0] rs1, rs2, rd;
  logic [XLEN-1:0]   imm_i, imm_s;
  logic [XLEN-1:0]   op_a, op_b2;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign rs1    = REG_AW'(instr[19:15]);
  assign rs2    = REG_AW'(instr[24:20]);
  assign rd     = REG_AW'(instr[11:7]);
  assign imm_i  = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign imm_s  = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};

  // EX/MEM wins over MEM/WB; x0 always reads the register file value.
  function automatic logic [XLEN-1:0] fwd_sel(
    input logic [REG_AW-1:0] rs,
    input logic [XLEN-1:0]   rdata,
    input logic              f1v,
    input logic [REG_AW-1:0] f1rd,
    input logic [XLEN-1:0]   f1d,
    input logic              f2v,
    input logic [REG_AW-1:0] f2rd,
    input logic [XLEN-1:0]   f2d
  );
    if (f1v && f1rd == rs && rs != '0)      return f1d;
    else if (f2v && f2rd == rs && rs != '0) return f2d;
    else                                    return rdata;
  endfunction

  assign op_a  = fwd_sel(rs1, rs1_data, fwd1_valid, fwd1_rd, fwd1_data,
                         fwd2_valid, fwd2_rd, fwd2_data);
  assign op_b2 = fwd_sel(rs2, rs2_data, fwd1_valid, fwd1_rd, fwd1_data,
                         fwd2_valid, fwd2_rd, fwd2_data);

  logic              d_legal, d_use2, d_mr, d_mw, d_br, d_rw;
  logic [1:0]        d_aluop;
  logic [9:0]        d_func;
  logic [XLEN-1:0]   d_b;
  logic [REG_AW-1:0] d_rd;

  always_comb begin
    d_legal = 1'b1;
    d_use2  = 1'b0;
    d_mr    = 1'b0;
    d_mw    = 1'b0;
    d_br    = 1'b0;
    d_rw    = 1'b0;
    d_aluop = 2'd0;
    d_func  = {7'b0, funct3};
    d_b     = imm_i;
    d_rd    = '0;
    case (opcode)
      OP_R: begin
        d_aluop = 2'd2;
        d_func  = {instr[31:25], funct3};
        d_b     = op_b2;
        d_use2  = 1'b1;
        d_rw    = 1'b1;
        d_rd    = rd;
      end
      OP_I: begin
        d_aluop = 2'd2;
        d_rw    = 1'b1;
        d_rd    = rd;
      end
      OP_LOAD: begin
        d_mr = 1'b1;
        d_rw = 1'b1;
        d_rd = rd;
      end
      OP_STORE: begin
        d_b    = imm_s;
        d_use2 = 1'b1;
        d_mw   = 1'b1;
      end
      OP_BRANCH: begin
        d_aluop = 2'd1;
        d_b     = op_b2;
        d_use2  = 1'b1;
        d_br    = 1'b1;
      end
      default: begin
        d_legal = 1'b0;
        d_func  = '0;
      end
    endcase
  end

  // The load in the output register cannot forward its data yet.
  logic hazard;
  assign hazard = in_valid & out_valid & mem_read & (out_rd != '0) &
                  ((d_legal & (rs1 == out_rd)) | (d_use2 & (rs2 == out_rd)));
  assign in_ready = ~stall & ~hazard;

  // valid/ready: an instruction is consumed on an edge where in_valid and
  // in_ready are both high; otherwise upstream holds it unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      aluop      <= '0;
      funccode   <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      store_data <= '0;
      out_rd     <= '0;
      out_pc     <= '0;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      branch     <= 1'b0;
      reg_write  <= 1'b0;
      illegal    <= 1'b0;
    end else if (flush || (!stall && (hazard || !in_valid))) begin
      out_valid <= 1'b0;
      aluop     <= '0;
      funccode  <= '0;
      out_rd    <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      branch    <= 1'b0;
      reg_write <= 1'b0;
      illegal   <= 1'b0;
    end else if (!stall) begin
      out_valid  <= d_legal;
      illegal    <= ~d_legal;
      aluop      <= d_aluop;
      funccode   <= d_func;
      alu_a      <= op_a;
      alu_b      <= d_b;
      store_data <= op_b2;
      out_rd     <= d_rd;
      out_pc     <= pc;
      mem_read   <= d_mr;
      mem_write  <= d_mw;
      branch     <= d_br;
      reg_write  <= d_rw;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: a reference decode/pipeline model pushes expected
// register contents per cycle; each edge pops and compares against the DUT.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr, pc, rs1_data, rs2_data;
  logic        stall, flush;
  logic        fwd1_valid, fwd2_valid;
  logic [4:0]  fwd1_rd, fwd2_rd;
  logic [31:0] fwd1_data, fwd2_data;
  logic        out_valid;
  logic [1:0]  aluop;
  logic [9:0]  funccode;
  logic [31:0] alu_a, alu_b, store_data, out_pc;
  logic [4:0]  out_rd;
  logic        mem_read, mem_write, branch, reg_write, illegal;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .stall(stall), .flush(flush),
    .fwd1_valid(fwd1_valid), .fwd1_rd(fwd1_rd), .fwd1_data(fwd1_data),
    .fwd2_valid(fwd2_valid), .fwd2_rd(fwd2_rd), .fwd2_data(fwd2_data),
    .out_valid(out_valid), .aluop(aluop), .funccode(funccode),
    .alu_a(alu_a), .alu_b(alu_b), .store_data(store_data), .out_rd(out_rd),
    .out_pc(out_pc), .mem_read(mem_read), .mem_write(mem_write),
    .branch(branch), .reg_write(reg_write), .illegal(illegal)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [1:0]  aluop;
    logic [9:0]  fc;
    logic [4:0]  rd;
    logic        mr, mw, br, rw, ill;
    logic [31:0] a, b, sd, pc;
  } exp_t;
  localparam int EW = $bits(exp_t);

  logic [EW-1:0] exp_q[$];
  exp_t          mdl;
  int            checks = 0;
  int            failures = 0;
  logic          last_ready;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fw(input logic [4:0] rs, input logic [31:0] rdata);
    if (fwd1_valid && fwd1_rd == rs && rs != 5'd0) return fwd1_data;
    if (fwd2_valid && fwd2_rd == rs && rs != 5'd0) return fwd2_data;
    return rdata;
  endfunction

  function automatic exp_t dec(input logic [31:0] ins, input logic [31:0] pcv,
                               input logic [31:0] a, input logic [31:0] r2);
    exp_t e;
    logic [31:0] immi, imms;
    immi = {{20{ins[31]}}, ins[31:20]};
    imms = {{20{ins[31]}}, ins[31:25], ins[11:7]};
    e = '0;
    e.valid = 1'b1;
    e.pc = pcv;
    e.a = a;
    e.sd = r2;
    e.fc = {7'b0, ins[14:12]};
    case (ins[6:0])
      7'b0110011: begin e.aluop = 2; e.fc = {ins[31:25], ins[14:12]}; e.b = r2; e.rw = 1; e.rd = ins[11:7]; end
      7'b0010011: begin e.aluop = 2; e.b = immi; e.rw = 1; e.rd = ins[11:7]; end
      7'b0000011: begin e.aluop = 0; e.b = immi; e.mr = 1; e.rw = 1; e.rd = ins[11:7]; end
      7'b0100011: begin e.aluop = 0; e.b = imms; e.mw = 1; end
      7'b1100011: begin e.aluop = 1; e.b = r2; e.br = 1; end
      default: begin e = '0; e.ill = 1'b1; end
    endcase
    return e;
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_ctl"}, {aluop, funccode, out_rd, mem_read, mem_write, branch, reg_write, illegal}, 0);
    chk({tag, "_ops"}, {alu_a, alu_b}, 0);
    chk({tag, "_sd_pc"}, {store_data, out_pc}, 0);
  endtask

  // driver: present one cycle of stimulus, model the edge, compare after it
  task automatic cycle(input string tag, input logic iv, input logic [31:0] ins,
                       input logic [31:0] pcv, input logic [31:0] r1, input logic [31:0] r2,
                       input logic st, input logic fl);
    logic [6:0] op;
    logic legal, use2, hz;
    exp_t e;
    in_valid = iv; instr = ins; pc = pcv; rs1_data = r1; rs2_data = r2;
    stall = st; flush = fl;
    #1;
    op = ins[6:0];
    legal = op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011};
    use2  = op inside {7'b0110011, 7'b0100011, 7'b1100011};
    hz = iv && mdl.valid && mdl.mr && mdl.rd != 0 &&
         ((legal && ins[19:15] == mdl.rd) || (use2 && ins[24:20] == mdl.rd));
    last_ready = !st && !hz;
    chk({tag, "_in_ready"}, in_ready, last_ready);
    if (fl)              mdl = '0;
    else if (st)         mdl = mdl;
    else if (hz || !iv)  mdl = '0;
    else                 mdl = dec(ins, pcv, fw(ins[19:15], r1), fw(ins[24:20], r2));
    exp_q.push_back(mdl);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({tag, "_ctl"},
        {out_valid, aluop, funccode, out_rd, mem_read, mem_write, branch, reg_write, illegal},
        {e.valid, e.aluop, e.fc, e.rd, e.mr, e.mw, e.br, e.rw, e.ill});
    if (e.valid) begin
      chk({tag, "_a"}, alu_a, e.a);
      chk({tag, "_b"}, alu_b, e.b);
      chk({tag, "_pc"}, out_pc, e.pc);
      if (e.mw) chk({tag, "_sd"}, store_data, e.sd);
    end
  endtask

  task automatic set_fwd(input logic v1, input logic [4:0] d1, input logic [31:0] x1,
                         input logic v2, input logic [4:0] d2, input logic [31:0] x2);
    fwd1_valid = v1; fwd1_rd = d1; fwd1_data = x1;
    fwd2_valid = v2; fwd2_rd = d2; fwd2_data = x2;
  endtask

  initial begin
    logic [31:0] ins;
    rst_n = 1'b0; in_valid = 0; instr = 0; pc = 0; rs1_data = 0; rs2_data = 0;
    stall = 0; flush = 0; mdl = '0; last_ready = 1'b1;
    set_fwd(0, 0, 0, 0, 0, 0);
    #12;
    chk_reset("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // directed cases
    cycle("add", 1, 32'h002081B3, 32'h100, 32'h17, 32'hd, 0, 0);
    chk("add_a_const", alu_a, 32'h17);
    chk("add_b_const", alu_b, 32'hd);
    chk("add_rd_const", out_rd, 3);
    cycle("sub", 1, 32'h40208133, 32'h104, 32'h17, 32'hd, 0, 0);
    chk("sub_fc_const", funccode, 10'd256);
    cycle("sw", 1, 32'hFE20AE23, 32'h108, 32'h100, 32'h55, 0, 0);
    chk("sw_b_const", alu_b, 32'hFFFFFFFC);
    chk("sw_sd_const", store_data, 32'h55);
    cycle("lw", 1, 32'h00C0A283, 32'h10C, 32'h200, 32'h0, 0, 0);
    chk("lw_b_const", alu_b, 32'hC);
    cycle("lu_hold", 1, 32'h00228333, 32'h110, 32'h1, 32'h2, 0, 0);
    chk("lu_ready_const", in_ready, 1'b1);
    chk("lu_bubble_const", out_valid, 1'b0);
    set_fwd(1, 5, 32'h1234, 0, 0, 0);
    cycle("lu_issue", 1, 32'h00228333, 32'h110, 32'h1, 32'h2, 0, 0);
    chk("lu_a_const", alu_a, 32'h1234);

    set_fwd(1, 1, 32'hAAAA, 1, 1, 32'hBBBB);
    cycle("fwd_pri", 1, 32'h002081B3, 32'h114, 32'h17, 32'hd, 0, 0);
    chk("fwd_pri_const", alu_a, 32'hAAAA);
    set_fwd(0, 1, 32'hAAAA, 1, 1, 32'hBBBB);
    cycle("fwd2", 1, 32'h002081B3, 32'h118, 32'h17, 32'hd, 0, 0);
    set_fwd(1, 0, 32'hDEAD, 1, 0, 32'hBEEF);
    cycle("fwd_x0", 1, 32'h00500193, 32'h11C, 32'h99, 32'h0, 0, 0);
    chk("fwd_x0_const", alu_a, 32'h99);
    set_fwd(0, 0, 0, 0, 0, 0);

    cycle("beq", 1, 32'h00208463, 32'h120, 32'h5, 32'h6, 0, 0);
    cycle("stall1", 1, 32'h40208133, 32'h124, 32'h1, 32'h2, 1, 0);
    cycle("stall2", 1, 32'h40208133, 32'h124, 32'h1, 32'h2, 1, 0);
    chk("stall_pc_const", out_pc, 32'h120);
    cycle("fl_st", 1, 32'h40208133, 32'h124, 32'h1, 32'h2, 1, 1);
    chk("fl_st_const", out_valid, 1'b0);
    cycle("illegal", 1, 32'h0000007F, 32'h128, 32'h1, 32'h2, 0, 0);
    chk("illegal_const", {illegal, out_valid}, 2'b10);
    cycle("idle", 0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0);

    // random mix; a refused instruction is re-presented unchanged
    ins = 32'h00000013;
    for (int i = 0; i < 60; i++) begin
      logic [6:0] ops[6];
      ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1111111};
      if (last_ready) begin
        ins = $urandom;
        ins[6:0]   = ops[$urandom_range(0, 5)];
        ins[19:15] = 5'($urandom_range(0, 3));
        ins[24:20] = 5'($urandom_range(0, 3));
        ins[11:7]  = 5'($urandom_range(0, 3));
      end
      set_fwd(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom,
              1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom);
      cycle("rand", 1'($urandom_range(0, 7) != 0), ins, $urandom, $urandom, $urandom,
            $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
    end
    set_fwd(0, 0, 0, 0, 0, 0);

    // asynchronous reset mid-stream
    cycle("pre_rst", 1, 32'h002081B3, 32'h200, 32'h7, 32'h8, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("mid_reset");
    in_valid = 0;
    mdl = '0;
    #1;
    rst_n = 1'b1;
    cycle("post_rst", 1, 32'h00C0A283, 32'h204, 32'h40, 32'h0, 0, 0);

    if (exp_q.size() != 0) chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
